// File: rtl/lcd_spi_rx_if.sv
// Bundles the SPI pins and the byte stream/status side of lcd_spi_rx.
// slave  : the receiver (samples SPI pins, drives the byte stream).
// master : the SPI driver / stream consumer (a testbench or SoC glue).
// Signals: spi_clk, spi_mosi, spi_cs (low active), spi_dc, spi_rst (low active),
//          out_valid/out_ready/out_data/out_dc stream, overflow/ovf_clr,
//          abort pulse, byte_count.
interface lcd_spi_rx_if;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_cs;
  logic        spi_dc;
  logic        spi_rst;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_dc;
  logic        overflow;
  logic        ovf_clr;
  logic        abort;
  logic [15:0] byte_count;

  modport slave (
    input  spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, out_ready, ovf_clr,
    output out_valid, out_data, out_dc, overflow, abort, byte_count
  );

  modport master (
    output spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, out_ready, ovf_clr,
    input  out_valid, out_data, out_dc, overflow, abort, byte_count
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// LCD SPI link receiver. Oversamples mode-0 SPI pins in the clk domain,
// deserialises MSB-first bytes, tags each with dc and queues them in a FIFO
// presented as a valid/ready stream.
// Ports: clk, rst (async, active high), bus (lcd_spi_rx_if.slave).
//
// state    | meaning
// ST_IDLE  | cs high (or LCD reset active); no byte in progress
// ST_SHIFT | cs low; shifting bits in on synchronised spi_clk rises
module lcd_spi_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  lcd_spi_rx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, mosi_sync, cs_sync, dc_sync, lrst_sync;
  logic sclk_s, mosi_s, cs_s, dc_s, lcd_rst_s;
  logic sclk_prev, sclk_rise;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [6:0] shift, shift_nxt;
  logic       push_vld, push_nxt;
  logic [8:0] push_data, push_data_nxt;
  logic       abort_q, abort_nxt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic          out_valid_q, overflow_q;
  logic [15:0]   byte_cnt_q;
  logic          pop, full, push_ok, drop;
  logic [8:0]    head;

  // cs and LCD reset synchronisers reset to their inactive (high) level so
  // that leaving reset never looks like a cs edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      lrst_sync <= '1;
      sclk_prev <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0],  bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   bus.spi_dc};
      lrst_sync <= {lrst_sync[SYNC_STAGES-2:0], bus.spi_rst};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = clk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign lcd_rst_s = lrst_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      push_vld  <= 1'b0;
      push_data <= 9'd0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      push_vld  <= push_nxt;
      push_data <= push_data_nxt;
      abort_q   <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    push_nxt      = 1'b0;
    push_data_nxt = push_data;
    abort_nxt     = 1'b0;
    if (!lcd_rst_s) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt_nxt = 3'd0;
          if (!cs_s) state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 3'd0;
            abort_nxt   = (bit_cnt != 3'd0);
          end else if (sclk_rise) begin
            shift_nxt = {shift[5:0], mosi_s};
            if (bit_cnt == 3'd7) begin
              // dc is taken together with the last (LSB) bit of the byte
              bit_cnt_nxt   = 3'd0;
              push_nxt      = 1'b1;
              push_data_nxt = {dc_s, shift, mosi_s};
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign pop     = out_valid_q & bus.out_ready;
  assign full    = (cnt == DEPTH_C);
  assign push_ok = push_vld & lcd_rst_s & (~full | pop);
  assign drop    = push_vld & lcd_rst_s & full & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop)      cnt_nxt = cnt + CNT_ONE;
    else if (!push_ok && pop) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // out_valid lags the occupancy by one cycle when filling from empty, so a
  // freshly written entry is never presented in the cycle it is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      byte_cnt_q  <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
      if (!lcd_rst_s) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        cnt         <= '0;
        out_valid_q <= 1'b0;
        byte_cnt_q  <= 16'd0;
      end else begin
        if (push_ok) begin
          wr_ptr     <= wr_ptr + PTR_ONE;
          byte_cnt_q <= byte_cnt_q + 16'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        cnt         <= cnt_nxt;
        out_valid_q <= (cnt_nxt != '0) && (cnt != '0);
      end
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_valid_q ? head[7:0] : 8'h00;
  assign bus.out_dc     = out_valid_q & head[8];
  assign bus.overflow   = overflow_q;
  assign bus.abort      = abort_q;
  assign bus.byte_count = byte_cnt_q;
endmodule

// File: tb/tb_lcd_spi_rx.sv
module tb_lcd_spi_rx;
  localparam int DEPTH = 4;
  localparam int HALF  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_spi_rx_if io();

  lcd_spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0]  m_q[$];
  logic [15:0] m_cnt = 16'd0;
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model of the receiver as seen from outside: a completed byte is kept if
  // there is room, otherwise it is dropped and overflow latches.
  task automatic model_byte(input logic [7:0] d, input logic dcv);
    if (m_q.size() < DEPTH) begin
      m_q.push_back({dcv, d});
      m_cnt = m_cnt + 16'd1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // mode 1: check out_valid latency on the 8th rise (FIFO empty beforehand)
  // mode 2: pop the head in the same cycle the byte is written
  task automatic send_bits(input logic [7:0] d, input logic dcv, input int nbits, input int mode);
    for (int b = 0; b < nbits; b++) begin
      io.spi_clk  = 1'b0;
      io.spi_mosi = d[7-b];
      io.spi_dc   = dcv;
      repeat (HALF) @(negedge clk);
      io.spi_clk = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (b == 7 && mode == 1 && k == 4) check("lat_e3_valid", io.out_valid, 0);
        if (b == 7 && mode == 1 && k == 5) check("lat_e4_valid", io.out_valid, 1);
        if (b == 7 && mode == 2 && k == 3) begin
          io.out_ready = 1'b1;
          check("same_cycle_head", {io.out_dc, io.out_data}, m_q[0]);
          void'(m_q.pop_front());
        end
        if (b == 7 && mode == 2 && k == 4) io.out_ready = 1'b0;
      end
    end
    if (nbits == 8) model_byte(d, dcv);
  endtask

  task automatic cs_low();
    io.spi_clk = 1'b0;
    io.spi_cs  = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high(input int exp_abort);
    int ab;
    ab = 0;
    io.spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    io.spi_cs = 1'b1;
    for (int k = 0; k < 3*HALF; k++) begin
      @(negedge clk);
      if (io.abort) ab++;
    end
    check("abort_cycles", ab, exp_abort);
  endtask

  task automatic drain();
    int t;
    io.out_ready = 1'b1;
    while (m_q.size() > 0) begin
      t = 0;
      while (!io.out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!io.out_valid) begin
        check("drain_valid", io.out_valid, 1);
        m_q.delete();
      end else begin
        check("drain_head", {io.out_dc, io.out_data}, m_q.pop_front());
        @(negedge clk);
      end
    end
    io.out_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", io.out_valid, 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ovf"}, io.overflow, m_ovf);
    check({tag, "_cnt"}, io.byte_count, m_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, io.out_valid, 0);
    check({tag, "_data"}, io.out_data, 0);
    check({tag, "_dc"}, io.out_dc, 0);
    check({tag, "_ovf"}, io.overflow, 0);
    check({tag, "_abort"}, io.abort, 0);
    check({tag, "_cnt"}, io.byte_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rdc;
    int         n;

    io.spi_clk = 1'b0; io.spi_mosi = 1'b0; io.spi_cs = 1'b1; io.spi_dc = 1'b0;
    io.spi_rst = 1'b1; io.out_ready = 1'b0; io.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // two tagged bytes, latency on the first
    cs_low();
    send_bits(8'h2A, 1'b0, 8, 1);
    send_bits(8'h55, 1'b1, 8, 0);
    cs_high(0);
    check_status("two_bytes");
    drain();

    // overflow on the fifth byte, then clear and drain
    cs_low();
    for (int i = 1; i <= 5; i++) send_bits(8'(i), 1'b1, 8, 0);
    cs_high(0);
    check_status("overflow");
    io.ovf_clr = 1'b1;
    @(negedge clk);
    io.ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check("ovf_cleared", io.overflow, m_ovf);
    drain();

    // full FIFO with a pop coinciding with the push
    cs_low();
    for (int i = 0; i < DEPTH; i++) send_bits(8'($urandom), 1'($urandom), 8, 0);
    send_bits(8'hA5, 1'b0, 8, 2);
    cs_high(0);
    check_status("same_cycle");
    drain();

    // partial byte aborted, next frame intact
    cs_low();
    send_bits(8'hFF, 1'b1, 5, 0);
    cs_high(1);
    check("abort_no_push", io.out_valid, 0);
    check_status("abort");
    cs_low();
    send_bits(8'hC3, 1'b0, 8, 0);
    cs_high(0);
    drain();

    // random bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      cs_low();
      for (int i = 0; i < n; i++) begin
        rd  = 8'($urandom);
        rdc = 1'($urandom);
        send_bits(rd, rdc, 8, 0);
      end
      cs_high(0);
      check_status("random");
      if (m_ovf) begin
        io.ovf_clr = 1'b1;
        @(negedge clk);
        io.ovf_clr = 1'b0;
        m_ovf = 1'b0;
      end
      drain();
    end

    // byte_count wrap
    force dut.byte_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.byte_cnt_q;
    m_cnt = 16'hFFFF;
    cs_low();
    send_bits(8'h3C, 1'b1, 8, 0);
    cs_high(0);
    check_status("wrap");
    drain();

    // LCD reset flushes the FIFO and count, keeps overflow
    cs_low();
    for (int i = 0; i < 5; i++) send_bits(8'($urandom), 1'($urandom), 8, 0);
    cs_high(0);
    check_status("pre_lcd_rst");
    io.spi_rst = 1'b0;
    repeat (10) @(negedge clk);
    io.spi_rst = 1'b1;
    repeat (4) @(negedge clk);
    m_q.delete();
    m_cnt = 16'd0;
    check("lcd_rst_valid", io.out_valid, 0);
    check_status("lcd_rst");
    io.ovf_clr = 1'b1;
    @(negedge clk);
    io.ovf_clr = 1'b0;
    m_ovf = 1'b0;

    // async reset in the middle of a byte with data buffered
    cs_low();
    send_bits(8'h81, 1'b1, 8, 0);
    send_bits(8'h7E, 1'b0, 8, 0);
    send_bits(8'hB4, 1'b1, 3, 0);
    io.spi_clk = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    m_q.delete();
    m_cnt = 16'd0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cs_high(0);
    check_status("post_rst");
    cs_low();
    send_bits(8'hC3, 1'b1, 8, 1);
    cs_high(0);
    check_status("final");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
